// File: rtl/async_dualport_ram.sv
// -----------------------------------------------------------------------------
// async_dualport_ram
//
// Purpose:
//   Simple dual-port RAM with one write port and one independent read port on
//   a single clock. Reads are registered (1-cycle latency). When a read and a
//   write hit the same address on the same edge, the read returns the new
//   write data (write-first).
//
// Ports:
//   clk       in   1           rising-edge clock for both ports
//   rst       in   1           asynchronous, active-low reset; clears memory,
//                              data_out and rd_valid
//   data_in   in   DATA_WIDTH  write data
//   wr_en     in   1           write enable
//   rd_en     in   1           read enable
//   wr_addr   in   ADDR_WIDTH  write address
//   rd_addr   in   ADDR_WIDTH  read address
//   data_out  out  DATA_WIDTH  registered read data (held when no read)
//   rd_valid  out  1           high for the cycle after each sampled rd_en
//
// Read handshake: there is no back-pressure. A read is accepted on every
// rising edge where rd_en=1. After that edge, data_out carries the word and
// rd_valid=1 for exactly that cycle. Back-to-back reads keep rd_valid high.
// On an edge with rd_en=0, rd_valid drops and data_out keeps its last value.
// -----------------------------------------------------------------------------
module async_dualport_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;

    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // A same-address write on this edge has not reached r_mem yet, so the
    // read is served straight from data_in to give write-first behaviour.
    assign w_bypass  = wr_en && (wr_addr == rd_addr);
    assign w_rd_word = w_bypass ? data_in : r_mem[rd_addr];

    // Memory array. Reset clears every word so that unwritten locations read 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= data_in;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_data_out <= w_rd_word;
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_async_dualport_ram.sv
module tb_async_dualport_ram;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 8;

    // ---------------- clock / reset ----------------
    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DATA_WIDTH-1:0] data_in = '0;
    logic                  wr_en = 1'b0;
    logic                  rd_en = 1'b0;
    logic [ADDR_WIDTH-1:0] wr_addr = '0;
    logic [ADDR_WIDTH-1:0] rd_addr = '0;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;

    always #5 clk = ~clk;

    async_dualport_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .data_out(data_out),
        .rd_valid(rd_valid)
    );

    // ---------------- scoreboard ----------------
    int num_checks = 0;
    int num_errors = 0;
    logic [DATA_WIDTH-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [DATA_WIDTH-1:0] obs,
                             input logic [DATA_WIDTH-1:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of inputs on the falling edge, then return 1 time unit
    // after the following rising edge so outputs reflect that edge.
    task automatic do_cycle(input logic we, input logic [ADDR_WIDTH-1:0] wa,
                            input logic [DATA_WIDTH-1:0] wd, input logic re,
                            input logic [ADDR_WIDTH-1:0] ra);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        data_in = wd;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [ADDR_WIDTH-1:0] ra, input string tag,
                           input logic [DATA_WIDTH-1:0] exp);
        do_cycle(1'b0, '0, '0, 1'b1, ra);
        check_val({tag, "_data"}, data_out, exp);
        check_val({tag, "_valid"}, {15'd0, rd_valid}, 16'd1);
    endtask

    // Watchdog: the stimulus is a fixed short sequence on a free-running clock.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 100000", $time);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1. Reset
        #2 rst = 1'b0;
        #20;
        check_val("rst_data", data_out, 16'd0);
        check_val("rst_valid", {15'd0, rd_valid}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(ADDR_WIDTH'(i), $sformatf("rst_rd%0d", i), 16'd0);
        end

        // 2. Basic write / read
        do_cycle(1'b1, 3'd5, 16'd200, 1'b0, 3'd0);
        check_val("wr5_valid_low", {15'd0, rd_valid}, 16'd0);
        do_read(3'd5, "basic_rd5", 16'd200);

        // A disabled write must not land.
        do_cycle(1'b0, 3'd2, 16'd999, 1'b0, 3'd0);
        do_read(3'd2, "nowr_rd2", 16'd0);

        // 3. Independent ports
        do_cycle(1'b1, 3'd6, 16'd140, 1'b0, 3'd0);
        do_cycle(1'b1, 3'd1, 16'd50, 1'b0, 3'd0);
        do_cycle(1'b1, 3'd0, 16'd30, 1'b1, 3'd6);
        check_val("indep_rd6", data_out, 16'd140);
        check_val("indep_rd6_valid", {15'd0, rd_valid}, 16'd1);
        do_read(3'd0, "indep_rd0", 16'd30);
        do_read(3'd1, "indep_rd1", 16'd50);

        // 4. Collision, write-first
        do_cycle(1'b1, 3'd1, 16'd70, 1'b1, 3'd1);
        check_val("coll_data", data_out, 16'd70);
        check_val("coll_valid", {15'd0, rd_valid}, 16'd1);
        do_read(3'd1, "coll_rd1", 16'd70);

        // 5. Hold behaviour: data_out stays 70, rd_valid low
        exp_q.push_back(16'd70);
        exp_q.push_back(16'd70);
        exp_q.push_back(16'd70);
        do_cycle(1'b1, 3'd6, 16'd15, 1'b0, 3'd7);
        check_val("hold0_data", data_out, exp_q.pop_front());
        check_val("hold0_valid", {15'd0, rd_valid}, 16'd0);
        do_cycle(1'b1, 3'd7, 16'd60, 1'b0, 3'd7);
        check_val("hold1_data", data_out, exp_q.pop_front());
        check_val("hold1_valid", {15'd0, rd_valid}, 16'd0);
        do_cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
        check_val("hold2_data", data_out, exp_q.pop_front());
        check_val("hold2_valid", {15'd0, rd_valid}, 16'd0);
        do_read(3'd7, "hold_rd7", 16'd60);
        do_read(3'd6, "hold_rd6", 16'd15);

        // 6. Reset mid-operation
        do_cycle(1'b1, 3'd3, 16'd80, 1'b0, 3'd0);
        do_read(3'd3, "pre_rst_rd3", 16'd80);
        // Clock is high here; assert reset between edges.
        rst = 1'b0;
        #1;
        check_val("async_rst_data", data_out, 16'd0);
        check_val("async_rst_valid", {15'd0, rd_valid}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        do_read(3'd3, "post_rst_rd3", 16'd0);
        do_read(3'd5, "post_rst_rd5", 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
